// File: rtl/pattern_feed_arbiter.sv
// rtl/pattern_feed_arbiter.sv - round-robin feeder of one E/C pattern detector
// Grants a whole message to one requester, clears the detector, streams 2-bit symbols, reports C hits.
module pattern_feed_arbiter #(
  parameter int SYM_PER_WORD = 4,
  parameter int DRAIN_CYC    = 2,
  parameter int CNT_W        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0_valid,
  input  logic [2*SYM_PER_WORD-1:0] req0_data,
  input  logic                      req0_last,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [2*SYM_PER_WORD-1:0] req1_data,
  input  logic                      req1_last,
  output logic                      req1_ready,
  output logic [1:0]                grant,
  output logic                      sym_msb,
  output logic                      sym_lsb,
  output logic                      sym_en,
  output logic                      det_clear,
  input  logic                      first_letter_detected,
  input  logic                      second_letter_detected,
  output logic                      busy,
  output logic                      hit_valid,
  output logic                      hit_id,
  output logic [CNT_W-1:0]          hit_count
);

  localparam int W     = 2 * SYM_PER_WORD;
  localparam int REM_W = $clog2(SYM_PER_WORD + 1);
  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(SYM_PER_WORD);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SEND, S_DRAIN, S_REPORT} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_srv_q, last_srv_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               msg_last_q, msg_last_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sld_prev_q, sld_prev_d;

  logic               ready0_q, ready0_d, ready1_q, ready1_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         sym_q, sym_d;
  logic               sym_en_q, sym_en_d;
  logic               det_clear_q, det_clear_d;
  logic               busy_q, busy_d;
  logic               hit_valid_q, hit_valid_d;
  logic               hit_id_q, hit_id_d;
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;

  logic               own_valid, own_ready, own_last, accept, sld_rise, ready_ok;
  logic [W-1:0]       own_data;

  // Only the C flag matters for counting; the E flag is deliberately unused.
  logic unused_first_letter;
  assign unused_first_letter = first_letter_detected;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_srv_d  = last_srv_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    msg_last_d  = msg_last_q;
    drain_d     = drain_q;
    cnt_d       = cnt_q;
    sld_prev_d  = second_letter_detected;
    sym_d       = 2'b00;
    sym_en_d    = 1'b0;

    own_valid   = owner_q ? req1_valid : req0_valid;
    own_ready   = owner_q ? ready1_q   : ready0_q;
    own_data    = owner_q ? req1_data  : req0_data;
    own_last    = owner_q ? req1_last  : req0_last;
    accept      = own_valid && own_ready;
    sld_rise    = second_letter_detected && !sld_prev_q && (cnt_q != CNT_MAX);

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = S_CLEAR;
          owner_d = (req0_valid && req1_valid) ? ~last_srv_q : req1_valid;
        end
      end
      S_CLEAR: begin
        state_d    = S_SEND;
        cnt_d      = '0;
        sld_prev_d = 1'b0;
        rem_d      = '0;
        msg_last_d = 1'b0;
        shreg_d    = '0;
      end
      S_SEND: begin
        if (sld_rise) cnt_d = cnt_q + CNT_W'(1);
        // rem_q counts symbols left including the one currently on the outputs.
        if (accept) begin
          sym_d      = own_data[W-1 -: 2];
          shreg_d    = {own_data[W-3:0], 2'b00};
          rem_d      = REM_FULL;
          msg_last_d = own_last;
          sym_en_d   = 1'b1;
        end else if (rem_q > REM_ONE) begin
          sym_d    = shreg_q[W-1 -: 2];
          shreg_d  = {shreg_q[W-3:0], 2'b00};
          rem_d    = rem_q - REM_ONE;
          sym_en_d = 1'b1;
        end else if (rem_q == REM_ONE) begin
          rem_d = '0;
          if (msg_last_q) begin
            state_d = S_DRAIN;
            drain_d = DRN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (sld_rise) cnt_d = cnt_q + CNT_W'(1);
        if (drain_q == '0) state_d = S_REPORT;
        else               drain_d = drain_q - DRN_W'(1);
      end
      S_REPORT: begin
        state_d    = S_IDLE;
        last_srv_d = owner_q;
      end
      default: state_d = S_IDLE;
    endcase

    ready_ok    = (state_d == S_SEND) && (rem_d <= REM_ONE) && !msg_last_d;
    ready0_d    = ready_ok && !owner_d;
    ready1_d    = ready_ok && owner_d;
    busy_d      = (state_d != S_IDLE);
    grant_d     = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    det_clear_d = (state_d == S_CLEAR);
    hit_valid_d = (state_d == S_REPORT);
    hit_id_d    = hit_valid_d && owner_d;
    hit_count_d = hit_valid_d ? cnt_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_srv_q  <= 1'b1;
      shreg_q     <= '0;
      rem_q       <= '0;
      msg_last_q  <= 1'b0;
      drain_q     <= '0;
      cnt_q       <= '0;
      sld_prev_q  <= 1'b0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      grant_q     <= 2'b00;
      sym_q       <= 2'b00;
      sym_en_q    <= 1'b0;
      det_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_id_q    <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_srv_q  <= last_srv_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      msg_last_q  <= msg_last_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      sld_prev_q  <= sld_prev_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      grant_q     <= grant_d;
      sym_q       <= sym_d;
      sym_en_q    <= sym_en_d;
      det_clear_q <= det_clear_d;
      busy_q      <= busy_d;
      hit_valid_q <= hit_valid_d;
      hit_id_q    <= hit_id_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;
  assign grant      = grant_q;
  assign sym_msb    = sym_q[1];
  assign sym_lsb    = sym_q[0];
  assign sym_en     = sym_en_q;
  assign det_clear  = det_clear_q;
  assign busy       = busy_q;
  assign hit_valid  = hit_valid_q;
  assign hit_id     = hit_id_q;
  assign hit_count  = hit_count_q;

endmodule

// File: tb/tb_pattern_feed_arbiter.sv
// tb/tb_pattern_feed_arbiter.sv - directed bench for pattern_feed_arbiter
// Two instances (CNT_W=4 and CNT_W=2) share stimulus; each drives its own E/C detector model.
module tb_pattern_feed_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;

  logic       ready0, ready1, sym_msb, sym_lsb, sym_en, det_clear, busy, hit_valid, hit_id, fld, sld;
  logic [1:0] grant;
  logic [3:0] hit_count;
  logic       s_ready0, s_ready1, s_sym_msb, s_sym_lsb, s_sym_en, s_det_clear, s_busy;
  logic       s_hit_valid, s_hit_id, s_fld, s_sld;
  logic [1:0] s_grant, s_hit_count;

  pattern_feed_arbiter #(.SYM_PER_WORD(4), .DRAIN_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(ready0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(ready1),
    .grant(grant), .sym_msb(sym_msb), .sym_lsb(sym_lsb), .sym_en(sym_en), .det_clear(det_clear),
    .first_letter_detected(fld), .second_letter_detected(sld),
    .busy(busy), .hit_valid(hit_valid), .hit_id(hit_id), .hit_count(hit_count)
  );

  pattern_feed_arbiter #(.SYM_PER_WORD(4), .DRAIN_CYC(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(s_ready0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(s_ready1),
    .grant(s_grant), .sym_msb(s_sym_msb), .sym_lsb(s_sym_lsb), .sym_en(s_sym_en), .det_clear(s_det_clear),
    .first_letter_detected(s_fld), .second_letter_detected(s_sld),
    .busy(s_busy), .hit_valid(s_hit_valid), .hit_id(s_hit_id), .hit_count(s_hit_count)
  );

  // Detector model: C flag one cycle after the last four enabled symbols spell 0xEC.
  logic [5:0] win, s_win;
  always @(posedge clk) begin
    if (reset || det_clear) begin
      win <= '0; sld <= 1'b0; fld <= 1'b0;
    end else begin
      sld <= 1'b0; fld <= 1'b0;
      if (sym_en) begin
        win <= {win[3:0], sym_msb, sym_lsb};
        if ({win, sym_msb, sym_lsb} == 8'hEC) sld <= 1'b1;
        if ({win[1:0], sym_msb, sym_lsb} == 4'hE) fld <= 1'b1;
      end
    end
  end
  always @(posedge clk) begin
    if (reset || s_det_clear) begin
      s_win <= '0; s_sld <= 1'b0; s_fld <= 1'b0;
    end else begin
      s_sld <= 1'b0; s_fld <= 1'b0;
      if (s_sym_en) begin
        s_win <= {s_win[3:0], s_sym_msb, s_sym_lsb};
        if ({s_win, s_sym_msb, s_sym_lsb} == 8'hEC) s_sld <= 1'b1;
        if ({s_win[1:0], s_sym_msb, s_sym_lsb} == 4'hE) s_fld <= 1'b1;
      end
    end
  end

  logic [1:0] sym_log[$];
  int hit_ids[$], hit_cnts[$], sat_cnts[$];
  int run = 0, max_run = 0, clr_cnt = 0;
  always @(negedge clk) begin
    if (sym_en) begin
      sym_log.push_back({sym_msb, sym_lsb});
      run = run + 1;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (det_clear) clr_cnt = clr_cnt + 1;
    if (hit_valid) begin
      hit_ids.push_back(int'(hit_id));
      hit_cnts.push_back(int'(hit_count));
    end
    if (s_hit_valid) sat_cnts.push_back(int'(s_hit_count));
  end

  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    sym_log.delete(); hit_ids.delete(); hit_cnts.delete(); sat_cnts.delete();
    run = 0; max_run = 0; clr_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_word(input int id, input logic [7:0] d, input logic last);
    int waited = 0;
    bit accepted = 0;
    if (id == 0) begin req0_valid = 1'b1; req0_data = d; req0_last = last; end
    else         begin req1_valid = 1'b1; req1_data = d; req1_last = last; end
    while (!accepted && waited < 200) begin
      @(negedge clk);
      if ((id == 0) ? ready0 : ready1) accepted = 1;
      @(posedge clk); #1;
      waited++;
    end
    if (!accepted) check($sformatf("send_timeout_req%0d", id), 0, 1);
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_reports(input int n);
    int w = 0;
    while (hit_ids.size() < n && w < 400) begin
      @(posedge clk); w++;
    end
    if (hit_ids.size() < n) check("report_timeout", hit_ids.size(), n);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [5:0] exp_t1 [1:10];
  logic [1:0] exp_ec [0:3];
  logic [1:0] exp_t4 [0:7];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {det_clear, ready0, sym_en, sym[1:0], hit_valid} for cycles t+1..t+10
    exp_t1[1] = 6'b100000; exp_t1[2] = 6'b010000; exp_t1[3] = 6'b001110;
    exp_t1[4] = 6'b001100; exp_t1[5] = 6'b001110; exp_t1[6] = 6'b001000;
    exp_t1[7] = 6'b000000; exp_t1[8] = 6'b000000; exp_t1[9] = 6'b000001;
    exp_t1[10] = 6'b000000;
    exp_ec[0] = 2'd3; exp_ec[1] = 2'd2; exp_ec[2] = 2'd3; exp_ec[3] = 2'd0;
    exp_t4[0] = 2'd0; exp_t4[1] = 2'd0; exp_t4[2] = 2'd3; exp_t4[3] = 2'd2;
    exp_t4[4] = 2'd3; exp_t4[5] = 2'd0; exp_t4[6] = 2'd0; exp_t4[7] = 2'd1;

    // 1: reset state, then one-word message with cycle-exact timing
    do_reset();
    @(negedge clk);
    check("reset_outputs", {ready0, ready1, grant, sym_en, det_clear, busy, hit_valid, hit_id, hit_count}, 0);
    check("reset_outputs_sat", {s_ready0, s_ready1, s_grant, s_sym_en, s_det_clear, s_busy, s_hit_valid, s_hit_count}, 0);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'hEC; req0_last = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 3) req0_valid = 1'b0;
      @(negedge clk);
      check($sformatf("t1_ctrl_k%0d", k), {det_clear, ready0, sym_en, sym_msb, sym_lsb, hit_valid}, exp_t1[k]);
      check($sformatf("t1_grant_k%0d", k), {grant, busy}, (k <= 9) ? 3'b011 : 3'b000);
      if (k == 9) check("t1_hit", {hit_id, hit_count}, 5'd1);
    end

    // 2: simultaneous requests after reset alternate starting with req0
    do_reset();
    clear_logs();
    fork
      send_word(0, 8'hEC, 1'b1);
      send_word(1, 8'hEC, 1'b1);
    join
    wait_reports(2);
    if (hit_ids.size() >= 2) begin
      check("t2_first_id", hit_ids[0], 0);
      check("t2_second_id", hit_ids[1], 1);
      check("t2_counts", {hit_cnts[0][3:0], hit_cnts[1][3:0]}, 8'h11);
    end
    check("t2_clears", clr_cnt, 2);
    clear_logs();
    fork
      send_word(0, 8'hEC, 1'b1);
      send_word(1, 8'hEC, 1'b1);
    join
    wait_reports(2);
    if (hit_ids.size() >= 2) check("t2_pair2_order", {hit_ids[0][0], hit_ids[1][0]}, 2'b01);

    // 3: req1 back-to-back words stream without bubbles
    clear_logs();
    send_word(1, 8'hEC, 1'b0);
    send_word(1, 8'hEC, 1'b1);
    wait_reports(1);
    check("t3_max_run", max_run, 8);
    check("t3_nsym", sym_log.size(), 8);
    for (int i = 0; i < 8 && i < sym_log.size(); i++)
      check($sformatf("t3_sym%0d", i), sym_log[i], exp_ec[i % 4]);
    if (hit_ids.size() >= 1) check("t3_hit", {hit_ids[0][0], hit_cnts[0][3:0]}, 5'h12);

    // 4: valid gap between words; E/C straddles the gap
    clear_logs();
    send_word(0, 8'h0E, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    send_word(0, 8'hC1, 1'b1);
    wait_reports(1);
    check("t4_max_run", max_run, 4);
    check("t4_nsym", sym_log.size(), 8);
    for (int i = 0; i < 8 && i < sym_log.size(); i++)
      check($sformatf("t4_sym%0d", i), sym_log[i], exp_t4[i]);
    if (hit_ids.size() >= 1) check("t4_hit", {hit_ids[0][0], hit_cnts[0][3:0]}, 5'h01);

    // 5: five hits saturate the 2-bit counter at 3
    clear_logs();
    for (int i = 0; i < 5; i++) send_word(0, 8'hEC, (i == 4));
    wait_reports(1);
    check("t5_max_run", max_run, 20);
    if (sat_cnts.size() >= 1) check("t5_sat_count", sat_cnts[0], 3);
    else check("t5_sat_report", sat_cnts.size(), 1);
    if (hit_cnts.size() >= 1) check("t5_wide_count", hit_cnts[0], 5);

    // 6: reset in SEND aborts without a report; next message is cleared again
    clear_logs();
    req0_valid = 1'b1; req0_data = 8'hEC; req0_last = 1'b0;
    begin
      int w = 0;
      @(negedge clk);
      while (!sym_en && w < 50) begin @(negedge clk); w++; end
      if (!sym_en) check("t6_send_timeout", 0, 1);
    end
    @(posedge clk); #1;
    reset = 1'b1; req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_after_reset", {grant, sym_en, busy, ready0, hit_valid}, 0);
    repeat (12) @(posedge clk);
    #1;
    check("t6_no_report", hit_ids.size() + sat_cnts.size(), 0);
    clear_logs();
    send_word(0, 8'hEC, 1'b1);
    wait_reports(1);
    check("t6_clear_pulse", clr_cnt, 1);
    check("t6_nsym", sym_log.size(), 4);
    if (hit_ids.size() >= 1) check("t6_hit", {hit_ids[0][0], hit_cnts[0][3:0]}, 5'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
